// File: rtl/dot_product_accum.sv
// Streaming signed saturating multiply-accumulate, one narrowed result per vector.
// Define DPA_ROUND_EN for round-half-up narrowing instead of truncation.
module dot_product_accum #(
  parameter int IN_W  = 13,
  parameter int ACC_W = 26,
  parameter int OUT_W = 19,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic signed [IN_W-1:0]  in_a,
  input  logic signed [IN_W-1:0]  in_b,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] out_acc,
  output logic signed [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_ovf
);

  localparam int PW = 2 * IN_W;
  localparam int SH = ACC_W - OUT_W;

  localparam logic signed [ACC_W-1:0] AMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AMIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CMAX = '1;

  typedef enum logic {IDLE, ACCUM} state_t;

  logic signed [PW-1:0]    p_reg;
  logic                    p_valid;
  logic                    p_last;

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    ovf;
  logic                    done;

  logic signed [ACC_W:0]   p_ext;
  logic signed [ACC_W:0]   sum;
  logic                    sat_hit;
  logic signed [ACC_W-1:0] sat_val;

  logic signed [OUT_W-1:0] narrow;
  logic                    rnd_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_reg   <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
    end else begin
      p_reg   <= in_a * in_b;
      p_valid <= in_valid;
      p_last  <= in_valid & in_last;
    end
  end

  // One extra bit of headroom exposes overflow as a sign mismatch.
  always_comb begin
    p_ext   = (ACC_W+1)'(p_reg);
    sum     = (ACC_W+1)'(acc) + p_ext;
    sat_hit = sum[ACC_W] ^ sum[ACC_W-1];
    sat_val = sum[ACC_W-1:0];
    if (sat_hit)
      sat_val = sum[ACC_W] ? AMIN : AMAX;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (p_valid) begin
        unique case (state)
          IDLE: begin
            acc <= p_ext[ACC_W-1:0];
            cnt <= CNT_W'(1);
            ovf <= 1'b0;
          end
          ACCUM: begin
            acc <= sat_val;
            cnt <= (cnt == CMAX) ? cnt : cnt + 1'b1;
            ovf <= ovf | sat_hit;
          end
          default: ;
        endcase
        state <= p_last ? IDLE : ACCUM;
        done  <= p_last;
      end
    end
  end

`ifdef DPA_ROUND_EN
  generate
    if (SH > 0) begin : g_rnd
      logic signed [ACC_W:0] rsum;
      logic signed [OUT_W:0] rsh;
      always_comb begin
        rsum    = (ACC_W+1)'(acc) + (ACC_W+1)'(1 << (SH-1));
        rsh     = (OUT_W+1)'(rsum >>> SH);
        rnd_ovf = rsh[OUT_W] ^ rsh[OUT_W-1];
        narrow  = rsh[OUT_W-1:0];
        if (rnd_ovf)
          narrow = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end else begin : g_nornd
      assign narrow  = acc;
      assign rnd_ovf = 1'b0;
    end
  endgenerate
`else
  assign narrow  = acc[ACC_W-1:SH];
  assign rnd_ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_data  <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= done;
      if (done) begin
        out_acc   <= acc;
        out_data  <= narrow;
        out_count <= cnt;
        out_ovf   <= ovf | rnd_ovf;
      end
    end
  end

endmodule

// File: tb/tb_dot_product_accum.sv
// Scoreboard bench for dot_product_accum against a plain-arithmetic vector model.
module tb_dot_product_accum;

  localparam int  IN_W  = 13;
  localparam int  ACC_W = 26;
  localparam int  OUT_W = 19;
  localparam int  CNT_W = 8;
  localparam int  SH    = ACC_W - OUT_W;
  localparam longint AMAX = (64'sd1 <<< (ACC_W-1)) - 1;
  localparam longint AMIN = -(64'sd1 <<< (ACC_W-1));
  localparam longint OMAX = (64'sd1 <<< (OUT_W-1)) - 1;
  localparam int  CMAX  = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_last = 1'b0;
  logic signed [IN_W-1:0]  in_a = '0;
  logic signed [IN_W-1:0]  in_b = '0;
  logic                    out_valid;
  logic signed [ACC_W-1:0] out_acc;
  logic signed [OUT_W-1:0] out_data;
  logic [CNT_W-1:0]        out_count;
  logic                    out_ovf;

  dot_product_accum #(
    .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_last(in_last),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_acc(out_acc),
    .out_data(out_data), .out_count(out_count),
    .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint acc;
    longint data;
    longint cnt;
    longint ovf;
    longint due;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int passes = 0;

  longint m_acc;
  int     m_cnt;
  int     m_ovf;
  int     m_len = 0;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_out_acc"},   longint'(out_acc), 0);
    chk({tag, "_out_data"},  longint'(out_data), 0);
    chk({tag, "_out_count"}, longint'(out_count), 0);
    chk({tag, "_out_ovf"},   longint'(out_ovf), 0);
  endtask

  task automatic send(int a, int b, bit last);
    longint p;
    longint s;
    exp_t   e;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = IN_W'(a);
    in_b     = IN_W'(b);
    in_last  = last;
    p = longint'(a) * longint'(b);
    if (m_len == 0) begin
      m_acc = p;
      m_cnt = 1;
      m_ovf = 0;
    end else begin
      s = m_acc + p;
      if (s > AMAX) begin s = AMAX; m_ovf = 1; end
      else if (s < AMIN) begin s = AMIN; m_ovf = 1; end
      m_acc = s;
      if (m_cnt < CMAX) m_cnt++;
    end
    m_len++;
    if (last) begin
      e.acc = m_acc;
      e.cnt = m_cnt;
      e.ovf = m_ovf;
`ifdef DPA_ROUND_EN
      e.data = (m_acc + (64'sd1 <<< (SH-1))) >>> SH;
      if (e.data > OMAX) begin e.data = OMAX; e.ovf = 1; end
`else
      e.data = m_acc >>> SH;
`endif
      e.due = cyc + 3;
      sbq.push_back(e);
      m_len = 0;
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = IN_W'($urandom);
      in_b     = IN_W'($urandom);
      in_last  = 1'($urandom);
    end
  endtask

  function automatic int rnd_op();
    return int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W-1));
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_acc",   longint'(out_acc), e.acc);
        chk("out_data",  longint'(out_data), e.data);
        chk("out_count", longint'(out_count), e.cnt);
        chk("out_ovf",   longint'(out_ovf), e.ovf);
        chk("latency",   longint'(cyc), e.due);
      end
    end
  end

  initial begin
    int len;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    idle(2);

    repeat (2) send(256, 256, 0);
    send(256, 256, 1);
    idle(4);

    repeat (2) send(256, 256, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    m_len = 0;
    @(negedge clk);
    chk_zero("midreset");
    rst = 1'b1;
    send(256, 256, 1);
    idle(4);

    send(-4096, -4096, 0);
    send(-4096, -4096, 1);
    send(1, 1, 1);

    repeat (2) send(-4096, 4095, 0);
    send(-4096, 4095, 1);
    send(-4096, 4095, 0);
    send(-4096, 4095, 1);

    send(16, 12, 1);
    send(1, 2, 1);
    send(3, 3, 0);
    idle(2);
    send(3, 3, 1);
    idle(3);

    for (int i = 0; i < 300; i++) begin
      send(1, 1, i == 299);
      if ($urandom_range(0, 9) == 0) idle(1);
    end

    for (int v = 0; v < 60; v++) begin
      len = int'($urandom_range(1, 5));
      for (int k = 0; k < len; k++) begin
        send(rnd_op(), rnd_op(), k == len - 1);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end
    end

    idle(6);
    chk("scoreboard_drained", longint'(sbq.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dot_product_accum.md
Name: dot_product_accum

Overview:
- Streaming signed multiply-accumulate stage.
- Consumes operand pairs, forms a running saturating dot product, and emits one narrowed result per vector.
- Sits directly upstream of the FF pipeline registers. out_acc (ACC_W, 26 b) and out_data (OUT_W, 19 b) drive the 26-bit and 19-bit FF instances.
- Frames vectors with valid/last; no backpressure.

Parameters:
IN_W, 13, signed operand width (product width = 2*IN_W)
ACC_W, 26, signed accumulator width; must be >= 2*IN_W
OUT_W, 19, signed narrowed output width; must be <= ACC_W
CNT_W, 8, term counter width

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (asserted when 0)
in_valid  input  1  operand pair valid this cycle
in_last  input  1  marks final pair of vector; ignored when in_valid=0
in_a  input  IN_W  signed operand A
in_b  input  IN_W  signed operand B
out_valid  output  1  one-cycle pulse, result valid
out_acc  output  ACC_W  full saturated accumulation
out_data  output  OUT_W  narrowed result
out_count  output  CNT_W  terms accumulated in vector (saturates at 2^CNT_W-1)
out_ovf  output  1  any saturation occurred in this vector

Behaviour:
- Reset (rst=0, async): all outputs 0; internal product register, accumulator, counter, sticky overflow cleared; FSM to IDLE. A partial vector is discarded with no output. Release is synchronous to clk in effect.
- Stage 1 (product register), every cycle:
  - p_reg <= in_a*in_b as a signed 2*IN_W value.
  - p_valid <= in_valid; p_last <= in_valid & in_last.
- Stage 2 (accumulate), FSM with states IDLE and ACCUM:
  - IDLE, p_valid=1: acc <= sign-extended p_reg; cnt <= 1; ovf <= 0. Go to ACCUM unless p_last.
  - ACCUM, p_valid=1: acc <= sat(acc + p_reg); cnt <= min(cnt+1, max); ovf <= ovf | saturated.
  - ACCUM, p_valid=0: hold all state (gaps allowed).
  - p_last=1 in either state: complete this cycle and go to IDLE. The next pair starts a new vector with no dead cycle.
- Saturation:
  - Compute the sum at ACC_W+1 bits.
  - Clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- Result, registered:
  - On completion, out_valid=1 for exactly one cycle.
  - out_acc, out_count and out_ovf take the final values and hold until the next completion.
- Latency:
  - Pair accepted at edge t with in_last → out_valid high after edge t+2.
  - A single-term vector is legal.
- Narrowing:
  - out_data = acc[ACC_W-1 : ACC_W-OUT_W], i.e. arithmetic shift right by SH = ACC_W-OUT_W (7 at defaults), truncating toward -inf.
- Back-to-back vectors (last on consecutive cycles): each produces its own out_valid pulse on consecutive cycles.
- in_valid=0 ignores in_a, in_b and in_last.

Optional Feature:
- DPA_ROUND_EN defined:
  - out_data = sat_OUT_W((acc + 2^(SH-1)) >>> SH), round-half-up.
  - Positive overflow from rounding clamps to 2^(OUT_W-1)-1 and sets out_ovf.
  - SH=0 means no rounding.
- Undefined: pure truncation as above; out_ovf reflects accumulator saturation only.

Test Plan:
- Reset mid-vector: feed 2 pairs (256,256) with no last, pull rst=0 for 1 cycle, then one pair (256,256) with last → single out_valid; out_acc=65536, out_data=512, out_count=1, out_ovf=0.
- Three-term vector (256,256)x3, last on third → out_valid exactly 2 cycles after third accept; out_acc=196608, out_data=1536, out_count=3.
- Positive saturation: (-4096,-4096)x2 → out_acc=33554431, out_data=262143 (19'h3ffff), out_ovf=1. The next vector (1,1) single → out_ovf=0, out_acc=1.
- Negative saturation: (-4096,4095)x3 → out_acc=-33554432, out_data=-262144, out_ovf=1. Same stimulus x2 → out_acc=-33546240, out_ovf=0.
- Gaps and back-to-back: (16,12) last; next cycle (1,2) last; then (3,3) with 2 idle cycles before (3,3) last → three pulses with out_acc=192, 2, 18 in order.
- Rounding (16,12) single:
  - Without DPA_ROUND_EN: out_data=1.
  - With DPA_ROUND_EN: out_data=2.
  - With DPA_ROUND_EN, (-4096,-4096)x2: out_data=262143, out_ovf=1.
